// File: rtl/lsu_ctrl.sv
// Load/store unit controller: computes the effective address, runs one bus access and returns load data to the register file.
// Latency: load done 3 cycles after start, store 2, misaligned/illegal 1; waits on mem_gnt_i/mem_rvalid_i extend it.
// Backpressure: the request is held stable until mem_gnt_i; start_i is ignored while busy; a timeout ends a stalled access with err_o.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] base_i,
  input  logic [11:0] offset_i,
  input  logic [31:0] sdata_i,
  input  logic [4:0]  rd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Counter value on the last cycle allowed in REQ/WAIT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] ea_q;
  logic [2:0]  f3_q;
  logic        store_q;
  logic [31:0] sdata_q;
  logic [4:0]  rd_q;
  logic [7:0]  tmo_cnt;

  logic [31:0] ea_nxt;
  logic        mis_nxt;
  logic        ill_nxt;
  logic        tmo_hit;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;
  logic [3:0]  be_dec;
  logic [31:0] wd_dec;

  // Effective address and access legality, evaluated on the inputs of the start cycle.
  always_comb begin
    ea_nxt  = base_i + {{20{offset_i[11]}}, offset_i};
    mis_nxt = (((funct3_i == 3'b001) || (funct3_i == 3'b101)) && ea_nxt[0]) ||
              ((funct3_i == 3'b010) && (ea_nxt[1:0] != 2'b00));
    ill_nxt = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111) ||
              (is_store_i && funct3_i[2]);
    tmo_hit = (tmo_cnt == TMO_LAST);
  end

  // Lane selection and sign/zero extension of the returned read word.
  always_comb begin
    lane_b = mem_rdata_i[7:0];
    case (ea_q[1:0])
      2'd1:    lane_b = mem_rdata_i[15:8];
      2'd2:    lane_b = mem_rdata_i[23:16];
      2'd3:    lane_b = mem_rdata_i[31:24];
      default: lane_b = mem_rdata_i[7:0];
    endcase
    lane_h = ea_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ld_ext = mem_rdata_i;
    case (f3_q)
      3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_ext = {24'd0, lane_b};
      3'b101:  ld_ext = {16'd0, lane_h};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  // Byte enables and lane-replicated store data from the latched access; zero when no request is up.
  always_comb begin
    be_dec = 4'b1111;
    wd_dec = sdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be_dec = 4'b0001 << ea_q[1:0];
        wd_dec = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        be_dec = ea_q[1] ? 4'b1100 : 4'b0011;
        wd_dec = {2{sdata_q[15:0]}};
      end
      default: begin
        be_dec = 4'b1111;
        wd_dec = sdata_q;
      end
    endcase
    mem_we_o    = mem_req_o & store_q;
    mem_addr_o  = mem_req_o ? {ea_q[31:2], 2'b00} : 32'd0;
    mem_be_o    = mem_req_o ? be_dec : 4'd0;
    mem_wdata_o = mem_req_o ? wd_dec : 32'd0;
  end

  // Access FSM with registered status, bus-request and register-file outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ea_q       <= '0;
      f3_q       <= '0;
      store_q    <= 1'b0;
      sdata_q    <= '0;
      rd_q       <= '0;
      tmo_cnt    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
      mem_req_o  <= 1'b0;
      rf_wr_en_o <= 1'b0;
      rf_rd_o    <= '0;
      rf_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            ea_q    <= ea_nxt;
            f3_q    <= funct3_i;
            store_q <= is_store_i;
            sdata_q <= sdata_i;
            rd_q    <= rd_i;
            busy_o  <= 1'b1;
            if (mis_nxt) begin
              state      <= S_DONE;
              done_o     <= 1'b1;
              misalign_o <= 1'b1;
            end else if (ill_nxt) begin
              state  <= S_DONE;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state     <= S_REQ;
              mem_req_o <= 1'b1;
              tmo_cnt   <= '0;
            end
          end
        end
        S_REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            if (store_q) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end else if (tmo_hit) begin
            mem_req_o <= 1'b0;
            state     <= S_DONE;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem_rvalid_i) begin
            rf_wdata_o <= ld_ext;
            rf_rd_o    <= rd_q;
            rf_wr_en_o <= (rd_q != 5'd0);
            state      <= S_DONE;
            done_o     <= 1'b1;
          end else if (tmo_hit) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
          err_o      <= 1'b0;
          rf_wr_en_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected completions and bus requests.
// A negedge monitor compares every done_o pulse and every cycle of mem_req_o against the queues.
// The DUT runs with TIMEOUT_CYCLES=4 so timeout boundaries are reachable in a few cycles.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] base_i = '0;
  logic [11:0] offset_i = '0;
  logic [31:0] sdata_i = '0;
  logic [4:0]  rd_i = '0;
  logic        busy_o, done_o, misalign_o, err_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        rf_wr_en_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .base_i(base_i), .offset_i(offset_i), .sdata_i(sdata_i),
    .rd_i(rd_i), .busy_o(busy_o), .done_o(done_o), .misalign_o(misalign_o),
    .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t_done;
    bit          mis;
    bit          err;
    bit          wr;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
  } bus_exp_t;

  done_exp_t dq[$];
  bus_exp_t  bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops and checks expectations whenever the DUT presents done_o or mem_req_o.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    done_exp_t e;
    bus_exp_t  b;
    if (rst_n) begin
      if (done_o) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL spurious_done: got done_o=1 want no completion (cycle %0d)", cyc);
        end else begin
          e = dq.pop_front();
          chk("done_cycle", cyc, e.t_done);
          chk("busy_at_done", busy_o, 1'b1);
          chk("misalign", misalign_o, e.mis);
          chk("err", err_o, e.err);
          chk("rf_wr_en", rf_wr_en_o, e.wr);
          if (e.wr) begin
            chk("rf_rd", rf_rd_o, e.rd);
            chk("rf_wdata", rf_wdata_o, e.wdata);
          end
        end
      end else begin
        chk("rf_wr_en_idle", rf_wr_en_o, 1'b0);
      end
      if (mem_req_o) begin
        if (bq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_req: got mem_req_o=1 addr %h want no request (cycle %0d)", mem_addr_o, cyc);
        end else begin
          b = bq[0];
          chk("mem_addr", mem_addr_o, b.addr);
          chk("mem_be", mem_be_o, b.be);
          chk("mem_we", mem_we_o, b.we);
          chk("mem_wdata", mem_wdata_o, b.wdata);
        end
      end
      if (prev_req && !mem_req_o && bq.size() > 0) void'(bq.pop_front());
    end
    prev_req <= mem_req_o;
  end

  // One access: flags[0] drives a stray rvalid in REQ, flags[1] pulses start_i while busy.
  task automatic op(input bit st, input logic [2:0] f3, input logic [31:0] base,
                    input logic [11:0] off, input logic [31:0] sd, input logic [4:0] rd,
                    input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                    input int lat, input bit mis, input bit err, input bit wr,
                    input logic [31:0] wdat, input bit has_bus, input logic [31:0] baddr,
                    input logic [3:0] bbe, input logic [31:0] bwd, input int flags);
    done_exp_t d;
    bus_exp_t  b;
    int n;
    @(posedge clk); #1;
    start_i = 1'b1; is_store_i = st; funct3_i = f3; base_i = base;
    offset_i = off; sdata_i = sd; rd_i = rd;
    d.t_done = cyc + lat; d.mis = mis; d.err = err; d.wr = wr; d.rd = rd; d.wdata = wdat;
    dq.push_back(d);
    if (has_bus) begin
      b.addr = baddr; b.be = bbe; b.we = st; b.wdata = bwd;
      bq.push_back(b);
    end
    @(posedge clk); #1;
    start_i = 1'b0; base_i = 32'hDEAD_0000; offset_i = 12'h5A5; sdata_i = '0; rd_i = 5'd0;
    funct3_i = 3'b111;
    if (gnt_dly >= 0) begin
      for (int k = 0; k < gnt_dly; k++) begin
        if (flags[0] && k == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; end
        if (flags[1] && k == 1) begin start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; base_i = '0; end
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0; start_i = 1'b0; mem_rdata_i = '0;
      end
      mem_gnt_i = 1'b1;
      @(posedge clk); #1;
      mem_gnt_i = 1'b0;
      if (rv_dly >= 0) begin
        for (int k = 0; k < rv_dly; k++) begin @(posedge clk); #1; end
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      end
    end
    n = 0;
    while (busy_o && n < 40) begin @(posedge clk); #1; n++; end
    chk("busy_clears", busy_o, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_status", {busy_o, done_o, misalign_o, err_o, mem_req_o, mem_we_o, rf_wr_en_o}, 7'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_be", mem_be_o, 4'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rf_rd", rf_rd_o, 5'd0);
    chk("rst_rf_wdata", rf_wdata_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //  st  f3      base          off      sdata         rd     rdata         gnt rv lat mis err wr  wdata         bus addr          be       bus wdata    flags
    op(0, 3'b000, 32'h0000_1000, 12'h003, 32'h0,        5'd5,  32'h80FF_0000, 0, 0, 3, 0, 0, 1, 32'hFFFF_FF80, 1, 32'h0000_1000, 4'b1000, 32'h0,        0); // LB
    op(0, 3'b101, 32'h0000_2002, 12'h000, 32'h0,        5'd7,  32'h8001_1234, 0, 0, 3, 0, 0, 1, 32'h0000_8001, 1, 32'h0000_2000, 4'b1100, 32'h0,        0); // LHU
    op(1, 3'b001, 32'h0000_0010, 12'hFFF, 32'h1111,     5'd0,  32'h0,        -1,-1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        0); // SH misaligned
    op(1, 3'b000, 32'h0000_0020, 12'h001, 32'h1234_56AB,5'd0,  32'h0,         3,-1, 5, 0, 0, 0, 32'h0,         1, 32'h0000_0020, 4'b0010, 32'hABAB_ABAB, 2); // SB, late gnt
    op(0, 3'b010, 32'h0000_0100, 12'h004, 32'h0,        5'd0,  32'hDEAD_BEEF, 0, 0, 3, 0, 0, 0, 32'h0,         1, 32'h0000_0104, 4'b1111, 32'h0,        0); // LW rd=0
    op(0, 3'b010, 32'h0000_0200, 12'h000, 32'h0,        5'd6,  32'h0,         0,-1, 5, 0, 1, 0, 32'h0,         1, 32'h0000_0200, 4'b1111, 32'h0,        0); // LW timeout in WAIT
    op(0, 3'b010, 32'h0000_0208, 12'h000, 32'h0,        5'd6,  32'h0,        -1,-1, 5, 0, 1, 0, 32'h0,         1, 32'h0000_0208, 4'b1111, 32'h0,        0); // LW timeout in REQ
    op(0, 3'b010, 32'h0000_0210, 12'h000, 32'h0,        5'd9,  32'h0BAD_F00D, 0, 2, 5, 0, 0, 1, 32'h0BAD_F00D, 1, 32'h0000_0210, 4'b1111, 32'h0,        0); // rvalid on timeout cycle
    op(0, 3'b011, 32'h0000_0300, 12'h000, 32'h0,        5'd1,  32'h0,        -1,-1, 1, 0, 1, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        0); // illegal 011
    op(1, 3'b100, 32'h0000_0300, 12'h000, 32'h0,        5'd0,  32'h0,        -1,-1, 1, 0, 1, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        0); // store BU illegal
    op(1, 3'b101, 32'h0000_0031, 12'h000, 32'h0,        5'd0,  32'h0,        -1,-1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        0); // misalign over illegal
    op(1, 3'b010, 32'h0000_0040, 12'h800, 32'hCAFE_BABE,5'd0,  32'h0,         0,-1, 2, 0, 0, 0, 32'h0,         1, 32'hFFFF_F840, 4'b1111, 32'hCAFE_BABE, 0); // SW wrap
    op(0, 3'b001, 32'h0000_0300, 12'h000, 32'h0,        5'd31, 32'h1234_F00D, 0, 0, 3, 0, 0, 1, 32'hFFFF_F00D, 1, 32'h0000_0300, 4'b0011, 32'h0,        0); // LH
    op(0, 3'b100, 32'h0000_04FF, 12'h002, 32'h0,        5'd2,  32'h0000_9A00, 0, 0, 3, 0, 0, 1, 32'h0000_009A, 1, 32'h0000_0500, 4'b0010, 32'h0,        0); // LBU
    op(0, 3'b000, 32'h0000_0600, 12'h000, 32'h0,        5'd3,  32'h0000_007F, 1, 0, 4, 0, 0, 1, 32'h0000_007F, 1, 32'h0000_0600, 4'b0001, 32'h0,        1); // stray rvalid in REQ
    op(0, 3'b010, 32'h0000_0102, 12'h000, 32'h0,        5'd4,  32'h0,        -1,-1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        0); // LW misaligned

    // Reset pulsed during WAIT, then a stale rvalid.
    begin
      bus_exp_t b;
      @(posedge clk); #1;
      start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; base_i = 32'h0000_0700;
      offset_i = '0; sdata_i = '0; rd_i = 5'd4;
      b.addr = 32'h0000_0700; b.be = 4'b1111; b.we = 1'b0; b.wdata = '0;
      bq.push_back(b);
      @(posedge clk); #1;
      start_i = 1'b0; mem_gnt_i = 1'b1;
      @(posedge clk); #1;
      mem_gnt_i = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("abort_busy", busy_o, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0055;
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("abort_done", done_o, 1'b0);
        chk("abort_rf_wr", rf_wr_en_o, 1'b0);
        chk("abort_idle", busy_o, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("done_queue_empty", dq.size(), 32'd0);
    chk("bus_queue_empty", bq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
